// File: rtl/mem_stage_pkg.sv
// Shared constants and types for the MEM pipeline stage: bus widths, load-data
// FSM states and the field layout of the EX->MEM payload.
package mem_stage_pkg;

   localparam int TO_MEM_W = 75;
   localparam int TO_WB_W  = 71;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_LIVE  = 2'd1,
      ST_HELD  = 2'd2
   } memState_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] aluResult;
      logic        rd1B;
      logic        rd2B;
      logic        rd4B;
      logic        rdSigned;
      logic [4:0]  dest;
      logic        grWe;
      logic        exSys;
   } memPayload_t;

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load extraction: selects the addressed byte/half/word from the
// read data and sign- or zero-extends it to 32 bits.
module mem_load_ext
   import mem_stage_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_off,
   input  logic        i_rd1B,
   input  logic        i_rd2B,
   input  logic        i_signed,
   output logic [31:0] o_result
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_byte   = 8'h00;
      w_half   = 16'h0000;
      o_result = i_rdata;
      unique case (i_off)
         2'd0:    w_byte = i_rdata[7:0];
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         default: w_byte = i_rdata[31:24];
      endcase
      w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
      if (i_rd1B) begin
         o_result = {{24{i_signed & w_byte[7]}}, w_byte};
      end else if (i_rd2B) begin
         o_result = {{16{i_signed & w_half[15]}}, w_half};
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: pipeline register, valid/allow handshake and a small FSM
// that freezes synchronous SRAM read data while WB stalls the instruction.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int TO_MEM_W = mem_stage_pkg::TO_MEM_W,
   parameter int TO_WB_W  = mem_stage_pkg::TO_WB_W
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                wb_ex,
   input  logic                WB_allow_in,
   input  logic                EX_to_MEM_valid,
   input  logic [TO_MEM_W-1:0] to_MEM_data,
   output logic                MEM_allow_in,
   output logic                MEM_to_WB_valid,
   output logic [TO_WB_W-1:0]  to_WB_data,
   input  logic [31:0]         data_sram_rdata,
   output logic [36:0]         MEM_forward
);

   memState_e   r_state;
   memState_e   w_nextState;
   memPayload_t r_payload;
   logic [31:0] r_holdData;

   logic        w_memValid;
   logic        w_readyGo;
   logic        w_accept;
   logic        w_capture;
   logic        w_isLoad;
   logic [31:0] w_rdata;
   logic [31:0] w_loadData;
   logic [31:0] w_finalResult;

   assign w_memValid      = (r_state != ST_EMPTY);
   assign w_readyGo       = 1'b1;
   assign MEM_allow_in    = ~w_memValid | (w_readyGo & WB_allow_in);
   assign MEM_to_WB_valid = w_memValid & w_readyGo;
   assign w_accept        = MEM_allow_in & EX_to_MEM_valid;
   assign w_capture       = (r_state == ST_LIVE) & ~WB_allow_in & ~wb_ex;

   // A flush always wins; otherwise an occupied stage either holds (WB stalled)
   // or retires and optionally takes the next instruction.
   always_comb begin
      w_nextState = r_state;
      if (wb_ex) begin
         w_nextState = ST_EMPTY;
      end else begin
         unique case (r_state)
            ST_EMPTY: w_nextState = w_accept ? ST_LIVE : ST_EMPTY;
            ST_LIVE,
            ST_HELD:  w_nextState = WB_allow_in ? (w_accept ? ST_LIVE : ST_EMPTY) : ST_HELD;
            default:  w_nextState = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_EMPTY;
         r_holdData <= 32'h0;
         r_payload  <= '0;
      end else begin
         r_state <= w_nextState;
         if (wb_ex) begin
            r_holdData <= 32'h0;
         end else if (w_capture) begin
            r_holdData <= data_sram_rdata;
         end
         if (w_accept) begin
            r_payload <= to_MEM_data;
         end
      end
   end

   // The SRAM only presents the data for one cycle; afterwards use the copy.
   assign w_rdata = (r_state == ST_HELD) ? r_holdData : data_sram_rdata;

   mem_load_ext u_loadExt (
      .i_rdata  (w_rdata),
      .i_off    (r_payload.aluResult[1:0]),
      .i_rd1B   (r_payload.rd1B),
      .i_rd2B   (r_payload.rd2B),
      .i_signed (r_payload.rdSigned),
      .o_result (w_loadData)
   );

   assign w_isLoad      = r_payload.rd1B | r_payload.rd2B | r_payload.rd4B;
   assign w_finalResult = w_isLoad ? w_loadData : r_payload.aluResult;

   assign to_WB_data  = {r_payload.pc, w_finalResult, r_payload.dest,
                         r_payload.grWe, r_payload.exSys};
   assign MEM_forward = {r_payload.dest & {5{w_memValid}}, w_finalResult};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: expected WB packets are queued when an
// instruction is driven and compared when the stage hands it to WB.
module tb_mem_stage;

   logic        clk;
   logic        reset;
   logic        wb_ex;
   logic        WB_allow_in;
   logic        EX_to_MEM_valid;
   logic [74:0] to_MEM_data;
   logic        MEM_allow_in;
   logic        MEM_to_WB_valid;
   logic [70:0] to_WB_data;
   logic [31:0] data_sram_rdata;
   logic [36:0] MEM_forward;

   typedef struct {
      logic [70:0] wb;
      logic [36:0] fwd;
   } expItem_t;

   expItem_t expQ[$];
   int       errorCount;
   int       checkCount;
   logic [31:0] rdArr[8];

   mem_stage dut (
      .clk             (clk),
      .reset           (reset),
      .wb_ex           (wb_ex),
      .WB_allow_in     (WB_allow_in),
      .EX_to_MEM_valid (EX_to_MEM_valid),
      .to_MEM_data     (to_MEM_data),
      .MEM_allow_in    (MEM_allow_in),
      .MEM_to_WB_valid (MEM_to_WB_valid),
      .to_WB_data      (to_WB_data),
      .data_sram_rdata (data_sram_rdata),
      .MEM_forward     (MEM_forward)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [70:0] actual, input logic [70:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model of the load result, written from the byte/half rules.
   function automatic logic [31:0] expResult(input logic [31:0] alu, input logic [31:0] rdata,
                                             input logic b, input logic h, input logic w, input logic s);
      logic [31:0] shifted;
      shifted = rdata >> (8 * alu[1:0]);
      if (b) return s ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
      if (h) begin
         shifted = alu[1] ? (rdata >> 16) : rdata;
         return s ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
      end
      if (w) return rdata;
      return alu;
   endfunction

   // Drives one instruction from EX this cycle and queues what WB should see.
   task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] alu,
                                input logic b, input logic h, input logic w, input logic s,
                                input logic [4:0] dest, input logic [31:0] rdata, input bit push);
      logic [31:0] res;
      expItem_t    item;
      res = expResult(alu, rdata, b, h, w, s);
      EX_to_MEM_valid = 1'b1;
      to_MEM_data     = {pc, alu, b, h, w, s, dest, 1'b1, 1'b0};
      if (push) begin
         item.wb  = {pc, res, dest, 1'b1, 1'b0};
         item.fwd = {dest, res};
         expQ.push_back(item);
      end
   endtask

   // Scoreboard: every handoff to WB must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset && MEM_to_WB_valid && WB_allow_in) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedOut", 71'(to_WB_data), 71'h0);
         end else begin
            expItem_t it;
            it = expQ.pop_front();
            checkOutput("toWB", to_WB_data, it.wb);
            checkOutput("fwd", 71'(MEM_forward), 71'(it.fwd));
         end
      end
   end

   initial begin
      errorCount      = 0;
      checkCount      = 0;
      reset           = 1'b1;
      wb_ex           = 1'b0;
      WB_allow_in     = 1'b1;
      EX_to_MEM_valid = 1'b0;
      to_MEM_data     = '0;
      data_sram_rdata = 32'h0;
      #12;
      checkOutput("rstValid", 71'(MEM_to_WB_valid), 71'd0);
      checkOutput("rstAllow", 71'(MEM_allow_in), 71'd1);
      checkOutput("rstFwd", 71'(MEM_forward), 71'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // Byte and half loads with sign/zero extension.
      applyStimulus(32'h1C00_0000, 32'h1C00_0103, 1, 0, 0, 1, 5'd3, 32'h80FF_FF12, 1);
      tick(); EX_to_MEM_valid = 1'b0; data_sram_rdata = 32'h80FF_FF12;
      applyStimulus(32'h1C00_0004, 32'h1C00_0103, 1, 0, 0, 0, 5'd4, 32'h80FF_FF12, 1);
      tick(); EX_to_MEM_valid = 1'b0; data_sram_rdata = 32'h80FF_FF12;
      applyStimulus(32'h1C00_0008, 32'h1C00_0202, 0, 1, 0, 0, 5'd6, 32'h1234_ABCD, 1);
      tick(); EX_to_MEM_valid = 1'b0; data_sram_rdata = 32'h1234_ABCD;
      applyStimulus(32'h1C00_000C, 32'h1C00_0202, 0, 1, 0, 1, 5'd7, 32'h1234_ABCD, 1);
      tick(); EX_to_MEM_valid = 1'b0; data_sram_rdata = 32'h1234_ABCD;
      tick();

      // Word load held across a three-cycle WB stall while the port changes.
      WB_allow_in = 1'b0;
      applyStimulus(32'h1C00_0010, 32'h1C00_0300, 0, 0, 1, 0, 5'd8, 32'h0BAD_F00D, 1);
      tick(); EX_to_MEM_valid = 1'b0; data_sram_rdata = 32'h0BAD_F00D;
      @(negedge clk); checkOutput("stall0", 71'(to_WB_data[38:7]), 71'h0BAD_F00D);
      tick(); data_sram_rdata = 32'hDEAD_BEEF;
      @(negedge clk); checkOutput("stall1", 71'(to_WB_data[38:7]), 71'h0BAD_F00D);
      checkOutput("stallAllow", 71'(MEM_allow_in), 71'd0);
      tick();
      @(negedge clk); checkOutput("stall2", 71'(to_WB_data[38:7]), 71'h0BAD_F00D);
      tick(); WB_allow_in = 1'b1;
      tick();

      // Non-load passes alu_result; forward dest drops once it leaves.
      applyStimulus(32'h1C00_0014, 32'h1C00_0040, 0, 0, 0, 0, 5'd5, 32'h5555_AAAA, 1);
      tick(); EX_to_MEM_valid = 1'b0;
      tick();
      @(negedge clk); checkOutput("fwdDestIdle", 71'(MEM_forward[36:32]), 71'd0);
      checkOutput("idleValid", 71'(MEM_to_WB_valid), 71'd0);
      tick();

      // Back-to-back random stream; rdata arrives the cycle after acceptance.
      for (int i = 0; i < 8; i++) rdArr[i] = $urandom;
      for (int i = 0; i < 8; i++) begin
         int kind;
         kind = $urandom_range(0, 3);
         applyStimulus(32'h1C00_1000 + 32'(i * 4), $urandom, kind == 1, kind == 2, kind == 3,
                       1'($urandom_range(0, 1)), 5'($urandom_range(1, 31)), rdArr[i], 1);
         if (i > 0) data_sram_rdata = rdArr[i-1];
         tick();
      end
      EX_to_MEM_valid = 1'b0;
      data_sram_rdata = rdArr[7];
      tick();
      tick();

      // Flush on the same edge as an accept.
      wb_ex = 1'b1;
      applyStimulus(32'h1C00_2000, 32'h1C00_0040, 0, 0, 0, 0, 5'd9, 32'h0, 0);
      tick(); wb_ex = 1'b0; EX_to_MEM_valid = 1'b0;
      @(negedge clk); checkOutput("flushValid", 71'(MEM_to_WB_valid), 71'd0);
      checkOutput("flushAllow", 71'(MEM_allow_in), 71'd1);
      checkOutput("flushFwd", 71'(MEM_forward[36:32]), 71'd0);
      tick();

      // Reset during HELD discards the held data asynchronously.
      WB_allow_in = 1'b0;
      applyStimulus(32'h1C00_3000, 32'h1C00_0300, 0, 0, 1, 0, 5'd10, 32'h1357_2468, 0);
      tick(); EX_to_MEM_valid = 1'b0; data_sram_rdata = 32'h1357_2468;
      tick();
      @(negedge clk); checkOutput("heldValid", 71'(MEM_to_WB_valid), 71'd1);
      #2 reset = 1'b1;
      #1;
      checkOutput("rstHeldValid", 71'(MEM_to_WB_valid), 71'd0);
      checkOutput("rstHeldFwd", 71'(MEM_forward), 71'd0);
      checkOutput("rstHeldHold", 71'(dut.r_holdData), 71'd0);
      @(negedge clk);
      reset = 1'b0;
      WB_allow_in = 1'b1;
      tick();
      @(negedge clk); checkOutput("postRstValid", 71'(MEM_to_WB_valid), 71'd0);
      tick();

      checkOutput("sbEmpty", 71'(expQ.size()), 71'd0);
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: MEM_stage

Interface
REQ-001 Parameter TO_MEM_W, default 75: width of the to_MEM_data bus from EX.
REQ-002 Parameter TO_WB_W, default 71: width of the to_WB_data bus to WB.
REQ-003 Port clk  in  1: single clock, rising edge.
REQ-004 Port reset  in  1: asynchronous, active-high reset.
REQ-005 Port wb_ex  in  1: exception flush from WB, synchronous, active-high.
REQ-006 Port WB_allow_in  in  1: WB can accept an instruction this cycle.
REQ-007 Port EX_to_MEM_valid  in  1: EX offers an instruction.
REQ-008 Port to_MEM_data  in  TO_MEM_W: payload {pc[31:0], alu_result[31:0], rd_1B, rd_2B, rd_4B, rd_signed, dest[4:0], gr_we, ex_SYS}, MSB first.
REQ-009 Port MEM_allow_in  out  1: MEM can accept from EX.
REQ-010 Port MEM_to_WB_valid  out  1: MEM offers an instruction to WB.
REQ-011 Port to_WB_data  out  TO_WB_W: {pc, final_result[31:0], dest, gr_we, ex_SYS}.
REQ-012 Port data_sram_rdata  in  32: synchronous SRAM read data, valid the cycle after EX asserted the request.
REQ-013 Port MEM_forward  out  37: {MEM_dest[4:0], final_result[31:0]} for ID bypass.

Function
REQ-014 MEM_ready_go SHALL be 1 whenever MEM_valid is 1; MEM_allow_in SHALL equal ~MEM_valid | (MEM_ready_go & WB_allow_in); MEM_to_WB_valid SHALL equal MEM_valid & MEM_ready_go.
REQ-015 On a rising edge with MEM_allow_in=1, MEM_valid SHALL load EX_to_MEM_valid, and the payload register SHALL load to_MEM_data only if EX_to_MEM_valid=1.
REQ-016 wb_ex=1 SHALL clear MEM_valid and the hold state on the next edge, overriding any simultaneous accept.
REQ-017 Load-data FSM states: EMPTY, LIVE (first valid cycle, rdata taken from the port), HELD (rdata taken from the hold register).
REQ-018 Transitions: accept -> LIVE; LIVE with WB_allow_in=0 -> HELD, capturing data_sram_rdata into the hold register; LIVE or HELD with WB_allow_in=1 -> LIVE on a new accept, else EMPTY; flush -> EMPTY.
REQ-019 The hold register SHALL remain stable in HELD for any stall length, so the load result does not change while WB stalls.
REQ-020 Effective read data SHALL be the hold register in HELD and data_sram_rdata otherwise.
REQ-021 Load extraction SHALL use alu_result[1:0] as the byte offset: byte = rdata[8*off+7 : 8*off]; half = rdata[31:16] when off[1]=1, else rdata[15:0]; word = rdata.
REQ-022 Byte and half results SHALL be sign-extended when rd_signed=1 and zero-extended otherwise.
REQ-023 final_result SHALL be the extended load data when any rd_* bit is 1, else alu_result.
REQ-024 MEM_dest SHALL equal dest AND-masked with MEM_valid; it SHALL be 0 when invalid, whatever gr_we is.
REQ-025 pc, dest, gr_we and ex_SYS SHALL pass through to to_WB_data unchanged; MEM adds zero cycles of latency beyond its pipeline register.

Reset
REQ-026 While reset=1, asynchronously: MEM_valid=0, FSM=EMPTY, hold register=0, payload register=0.
REQ-027 Consequently, during reset: MEM_to_WB_valid=0, MEM_allow_in=1, MEM_forward=0.
REQ-028 Reset asserted mid-stall SHALL discard the held data; no output SHALL depend on pre-reset state after release.

Structure
REQ-029 to_MEM_data_width and to_WB_data_width SHALL be defined in the shared constants.h and bound to TO_MEM_W and TO_WB_W.
REQ-030 Byte and half extraction and extension SHALL live in one combinational sub-module, mem_load_ext, with inputs (rdata, off, size bits, signed) and output (32-bit result).
REQ-031 The FSM, pipeline register and handshake SHALL reside in MEM_stage.

Verification
REQ-032 ld.b, addr offset 3, rdata=0x80FF_FF12, signed -> final_result=0xFFFF_FF80; with rd_signed=0 -> 0x0000_0080.
REQ-033 ld.h, offset 2, rdata=0x1234_ABCD, unsigned -> 0x0000_1234; with signed -> 0x0000_1234.
REQ-034 ld.w accepted, WB_allow_in=0 for 3 cycles, rdata port changed to 0xDEAD_BEEF after the first cycle -> final_result stays at the first-cycle value 0x0BAD_F00D until WB accepts.
REQ-035 Non-load instruction with alu_result=0x1C00_0040, dest=5 -> to_WB_data carries 0x1C00_0040, MEM_forward={5, 0x1C00_0040}; after the instruction leaves with no new accept -> MEM_forward dest=0.
REQ-036 wb_ex=1 on the same edge as an accept from EX -> MEM_valid=0 next cycle, FSM=EMPTY.
REQ-037 Reset asserted during HELD -> MEM_to_WB_valid=0 immediately (asynchronous), hold register=0.
